// File: rtl/vga_pkg.sv
// VGA timing defaults (640x480@60), colour field offsets and count helpers.
// Shared by the timing generator and its axis counters.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // {R,G,B} field index, multiplied by COLOR_W at the use site
  localparam int R_OFS = 2;
  localparam int G_OFS = 1;
  localparam int B_OFS = 0;

  function automatic int vga_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic bit vga_fits(
    input int total,
    input int w
  );
    return (total - 1) < (1 << w);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus active and sync window decode.
// o_wrap marks the enabled cycle in which the count returns to zero.
module vga_axis_counter #(
  parameter int CNT_W    = 10,
  parameter int TOTAL    = 800,
  parameter int ACTIVE   = 640,
  parameter int SYNC_BEG = 656,
  parameter int SYNC_END = 752
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync
);

  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TOTAL - 1);
  // one extra bit so window edges equal to TOTAL do not alias
  localparam logic [CNT_W:0] L_ACT = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] L_SB  = (CNT_W+1)'(SYNC_BEG);
  localparam logic [CNT_W:0] L_SE  = (CNT_W+1)'(SYNC_END);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_ext;
  logic             w_last;

  assign w_ext  = {1'b0, r_cnt};
  assign w_last = (r_cnt == L_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_wrap   = i_en & w_last;
  assign o_active = (w_ext < L_ACT);
  assign o_sync   = (w_ext >= L_SB) && (w_ext < L_SE);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered sync/DE/RGB.
// Define VGA_TEST_PATTERN_EN to add test_en and an 8-bar colour pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 1,
  parameter int CNT_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               pix_active,
  input  logic [3*COLOR_W-1:0] pix_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic L_HS = 1'(HS_POL);
  localparam logic L_VS = 1'(VS_POL);

  if (!vga_fits(H_TOTAL, CNT_W) || !vga_fits(V_TOTAL, CNT_W)) begin : g_cfg_err
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic w_h_wrap;
  logic w_h_act;
  logic w_h_sync;
  logic w_v_wrap_unused;
  logic w_v_act;
  logic w_v_sync;

  vga_axis_counter #(
    .CNT_W    (CNT_W),
    .TOTAL    (H_TOTAL),
    .ACTIVE   (H_ACTIVE),
    .SYNC_BEG (H_ACTIVE + H_FP),
    .SYNC_END (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (pix_ce),
    .o_cnt    (pix_x),
    .o_wrap   (w_h_wrap),
    .o_active (w_h_act),
    .o_sync   (w_h_sync)
  );

  vga_axis_counter #(
    .CNT_W    (CNT_W),
    .TOTAL    (V_TOTAL),
    .ACTIVE   (V_ACTIVE),
    .SYNC_BEG (V_ACTIVE + V_FP),
    .SYNC_END (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_h_wrap),
    .o_cnt    (pix_y),
    .o_wrap   (w_v_wrap_unused),
    .o_active (w_v_act),
    .o_sync   (w_v_sync)
  );

  assign pix_active = w_h_act & w_v_act;

  logic [3*COLOR_W-1:0] w_src;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] w_bar;

  // bar = floor(x*8/H_ACTIVE), found by threshold compare instead of a divider
  always_comb begin
    w_bar = '0;
    for (int i = 1; i < 8; i++) begin
      if ({pix_x, 3'b000} >= (CNT_W+3)'(i * H_ACTIVE)) begin
        w_bar = 3'(i);
      end
    end
  end

  assign w_src = test_en ?
    {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}} :
    pix_data;
`else
  assign w_src = pix_data;
`endif

  logic                 r_hs;
  logic                 r_vs;
  logic                 r_de;
  logic [3*COLOR_W-1:0] r_rgb;
  logic                 r_ls;
  logic                 r_fs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs  <= ~L_HS;
      r_vs  <= ~L_VS;
      r_de  <= 1'b0;
      r_rgb <= '0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else if (pix_ce) begin
      r_hs  <= w_h_sync ? L_HS : ~L_HS;
      r_vs  <= w_v_sync ? L_VS : ~L_VS;
      r_de  <= pix_active;
      r_rgb <= pix_active ? w_src : '0;
      r_ls  <= (pix_x == '0);
      r_fs  <= (pix_x == '0) && (pix_y == '0);
    end else begin
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end
  end

  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign red         = r_rgb[R_OFS*COLOR_W +: COLOR_W];
  assign green       = r_rgb[G_OFS*COLOR_W +: COLOR_W];
  assign blue        = r_rgb[B_OFS*COLOR_W +: COLOR_W];
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 640x480 instance plus a tiny 8x4 active-high instance.
// Inputs driven and outputs sampled on the falling edge.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b1;
  logic [2:0] pix_data = 3'b111;
  logic       test_en = 1'b0;

  logic [9:0] x, y;
  logic       act, hs, vs, de, r, g, b, ls, fs;
  logic [3:0] xs, ys;
  logic       act_s, hs_s, vs_s, de_s, r_s, g_s, b_s, ls_s, fs_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .pix_x       (x),
    .pix_y       (y),
    .pix_active  (act),
    .pix_data    (pix_data),
`ifdef VGA_TEST_PATTERN_EN
    .test_en     (test_en),
`endif
    .hsync       (hs),
    .vsync       (vs),
    .de          (de),
    .red         (r),
    .green       (g),
    .blue        (b),
    .line_start  (ls),
    .frame_start (fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1), .VS_POL (1), .COLOR_W (1), .CNT_W (4)
  ) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .pix_x       (xs),
    .pix_y       (ys),
    .pix_active  (act_s),
    .pix_data    (pix_data),
`ifdef VGA_TEST_PATTERN_EN
    .test_en     (test_en),
`endif
    .hsync       (hs_s),
    .vsync       (vs_s),
    .de          (de_s),
    .red         (r_s),
    .green       (g_s),
    .blue        (b_s),
    .line_start  (ls_s),
    .frame_start (fs_s)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    pix_ce = 1'b1;
    pix_data = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({x, y} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_cnt: x=%0d y=%0d, want 0 0", x, y);
    end
    n_vec++;
    if ({hs, vs, de, r, g, b, ls, fs} !== 8'b11000000) begin
      n_err++;
      $display("FAIL reset_out: %b, want 11000000", {hs, vs, de, r, g, b, ls, fs});
    end
    n_vec++;
    if ({hs_s, vs_s, de_s, r_s, g_s, b_s, ls_s, fs_s} !== 8'b00000000) begin
      n_err++;
      $display("FAIL reset_small: %b, want 00000000",
               {hs_s, vs_s, de_s, r_s, g_s, b_s, ls_s, fs_s});
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({x, y, xs, ys} !== 28'd0) begin
      n_err++;
      $display("FAIL release_cnt: x=%0d y=%0d xs=%0d ys=%0d, want 0", x, y, xs, ys);
    end
    @(negedge clk);
    n_vec++;
    if ({x, y} !== {10'd1, 10'd0}) begin
      n_err++;
      $display("FAIL first_step: x=%0d y=%0d, want 1 0", x, y);
    end
    n_vec++;
    if ({hs, vs, de, r, g, b, ls, fs} !== 8'b11111111) begin
      n_err++;
      $display("FAIL first_pixel: %b, want 11111111", {hs, vs, de, r, g, b, ls, fs});
    end
    n_vec++;
    if ({xs, hs_s, de_s, ls_s, fs_s} !== {4'd1, 4'b0111}) begin
      n_err++;
      $display("FAIL first_small: xs=%0d hs/de/ls/fs=%b, want 1 0111",
               xs, {hs_s, de_s, ls_s, fs_s});
    end
  endtask

  task automatic test_line();
    int n, de_n, hs_on, hs_n, rgb_bad, act_bad, extra;
    logic [2:0] exp_rgb;
    n = 0;
    while (!ls && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (ls !== 1'b1) begin
      n_err++;
      $display("FAIL line_wait: line_start=%b after %0d clks, want 1", ls, n);
    end
    de_n = 0; hs_on = -1; hs_n = 0; rgb_bad = 0; act_bad = 0; extra = 0;
    for (int k = 0; k < 800; k++) begin
      if (k > 0 && ls) extra++;
      if (de) de_n++;
      if (!hs) begin
        hs_n++;
        if (hs_on < 0) hs_on = k;
      end
      exp_rgb = (k < 640) ? 3'b111 : 3'b000;
      if ({r, g, b} !== exp_rgb) rgb_bad++;
      if (act !== (((k + 1) % 800) < 640)) act_bad++;
      @(negedge clk);
    end
    n_vec++;
    if (ls !== 1'b1 || extra != 0) begin
      n_err++;
      $display("FAIL line_period: ls@800=%b extra=%0d, want 1 0", ls, extra);
    end
    n_vec++;
    if (de_n != 640) begin
      n_err++;
      $display("FAIL de_count: %0d, want 640", de_n);
    end
    n_vec++;
    if (hs_on != 656 || hs_n != 96) begin
      n_err++;
      $display("FAIL hsync_win: start=%0d len=%0d, want 656 96", hs_on, hs_n);
    end
    n_vec++;
    if (rgb_bad != 0) begin
      n_err++;
      $display("FAIL rgb_blank: %0d bad clks, want 0", rgb_bad);
    end
    n_vec++;
    if (act_bad != 0) begin
      n_err++;
      $display("FAIL pix_active: %0d bad clks, want 0", act_bad);
    end
  endtask

  task automatic test_color_align();
    int bad;
    logic [2:0] exp_rgb;
    bad = 0;
    for (int k = 0; k < 800; k++) begin
      exp_rgb = (k < 640) ? 3'(k % 8) : 3'b000;
      if (k > 0 && {r, g, b} !== exp_rgb) bad++;
      pix_data = 3'((k + 1) % 8);
      @(negedge clk);
    end
    pix_data = 3'b111;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL color_align: %0d bad clks, want 0", bad);
    end
  endtask

  task automatic test_small_frame();
    int n, cnt_bad, hs_bad, vs_bad, de_bad, st_bad;
    n = 0;
    while (!fs_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (fs_s !== 1'b1) begin
      n_err++;
      $display("FAIL small_wait: frame_start=%b after %0d clks, want 1", fs_s, n);
    end
    cnt_bad = 0; hs_bad = 0; vs_bad = 0; de_bad = 0; st_bad = 0;
    for (int k = 0; k < 84; k++) begin
      if (xs !== 4'((k + 1) % 12) || ys !== 4'(((k + 1) / 12) % 7)) cnt_bad++;
      if (hs_s !== ((k % 12) >= 9 && (k % 12) <= 10)) hs_bad++;
      if (vs_s !== ((k / 12) == 5)) vs_bad++;
      if (de_s !== ((k % 12) < 8 && (k / 12) < 4) || r_s !== de_s) de_bad++;
      if (ls_s !== ((k % 12) == 0) || fs_s !== (k == 0)) st_bad++;
      @(negedge clk);
    end
    n_vec++;
    if (cnt_bad != 0) begin
      n_err++;
      $display("FAIL small_cnt: %0d bad clks, want 0", cnt_bad);
    end
    n_vec++;
    if (hs_bad != 0 || vs_bad != 0) begin
      n_err++;
      $display("FAIL small_sync: hs_bad=%0d vs_bad=%0d, want 0 0", hs_bad, vs_bad);
    end
    n_vec++;
    if (de_bad != 0) begin
      n_err++;
      $display("FAIL small_de: %0d bad clks, want 0", de_bad);
    end
    n_vec++;
    if (st_bad != 0 || fs_s !== 1'b1) begin
      n_err++;
      $display("FAIL small_strobe: bad=%0d fs@84=%b, want 0 1", st_bad, fs_s);
    end
  endtask

  task automatic test_ce_toggle();
    int n, fs_k, l1, l2, ls1, ls2, frz_bad;
    logic last_ce;
    logic [9:0] px;
    logic [3:0] pxs;
    n = 0;
    while (!fs_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    fs_k = -1; l1 = -1; l2 = -1; ls1 = -1; ls2 = -1; frz_bad = 0;
    last_ce = 1'b1; px = x; pxs = xs;
    for (int k = 0; k < 3300; k++) begin
      if (k > 0 && !last_ce) begin
        if (x !== px || xs !== pxs || {ls, fs, ls_s, fs_s} !== 4'b0000) frz_bad++;
      end
      if (k > 0 && fs_s && fs_k < 0) fs_k = k;
      if (ls) begin
        if (l1 < 0) l1 = k;
        else if (l2 < 0) l2 = k;
      end
      if (ls_s) begin
        if (ls1 < 0) ls1 = k;
        else if (ls2 < 0) ls2 = k;
      end
      px = x; pxs = xs;
      pix_ce = ~pix_ce;
      last_ce = pix_ce;
      @(negedge clk);
    end
    pix_ce = 1'b1;
    n_vec++;
    if (fs_k != 168) begin
      n_err++;
      $display("FAIL ce_frame: period=%0d, want 168", fs_k);
    end
    n_vec++;
    if (l2 - l1 != 1600 || l1 < 0) begin
      n_err++;
      $display("FAIL ce_line: period=%0d, want 1600", l2 - l1);
    end
    n_vec++;
    if (ls2 - ls1 != 24 || ls1 < 0) begin
      n_err++;
      $display("FAIL ce_line_small: period=%0d, want 24", ls2 - ls1);
    end
    n_vec++;
    if (frz_bad != 0) begin
      n_err++;
      $display("FAIL ce_freeze: %0d bad clks, want 0", frz_bad);
    end
  endtask

  task automatic test_reset_mid();
    repeat (37) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({x, y, xs, ys} !== 28'd0) begin
      n_err++;
      $display("FAIL mid_reset_cnt: x=%0d y=%0d xs=%0d, want 0", x, y, xs);
    end
    n_vec++;
    if ({hs, vs, de, r, ls, fs, hs_s, de_s} !== 8'b11000000) begin
      n_err++;
      $display("FAIL mid_reset_out: %b, want 11000000",
               {hs, vs, de, r, ls, fs, hs_s, de_s});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({x, y, ls, fs} !== {10'd1, 10'd0, 2'b11}) begin
      n_err++;
      $display("FAIL mid_restart: x=%0d y=%0d ls/fs=%b, want 1 0 11", x, y, {ls, fs});
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int n, bad;
    logic [2:0] exp_rgb;
    test_en = 1'b1;
    pix_data = 3'b000;
    @(negedge clk);
    n = 0;
    while (!ls && n < 2000) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    for (int k = 0; k < 800; k++) begin
      exp_rgb = (k < 640) ? 3'(k / 80) : 3'b000;
      if ({r, g, b} !== exp_rgb) bad++;
      @(negedge clk);
    end
    test_en = 1'b0;
    pix_data = 3'b111;
    n_vec++;
    if (bad != 0 || n >= 2000) begin
      n_err++;
      $display("FAIL test_pattern: %0d bad clks, want 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_color_align();
    test_small_frame();
    test_ce_toggle();
    test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
